execute_stage: RTL and testbench

- Execute stage of the 5-stage LEGv8 pipeline, between the ID/EX register and the memory stage.
- Resolves operand forwarding, decodes ALU control, runs the ALU and computes the branch target.
- Registers all results and control into the EX/MEM boundary register that drives the memory stage's *_MEM inputs.
- Supports stall (hold) and flush (squash) of that register.

---
 rtl/legv8_pkg.sv | 38 +++
 rtl/execute_stage_alu.sv | 29 ++
 rtl/execute_stage.sv | 146 ++++++++++++++
 tb/tb_execute_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline encodings: ALUOp, ALU control, R-type opcodes, forwarding selects.
package legv8_pkg;

  localparam int OPC_W = 11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_NOR   = 4'b1100
  } alu_ctrl_e;

  localparam logic [OPC_W-1:0] OPC_ADD = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR = 11'b10101010000;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic reg_write;
    logic branch;
    logic uncondbranch;
    logic mem_read;
    logic mem_write;
    logic mem2reg;
    logic alu_zero;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational 64-bit LEGv8 ALU; reusable outside the execute stage.
module alu
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  alu_ctrl_e                ctrl,
  output logic signed [DATA_W-1:0] result,
  output logic                     zero
);

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND:   result = a & b;
      ALU_ORR:   result = a | b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_PASSB: result = b;
      ALU_NOR:   result = ~(a | b);
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// LEGv8 execute stage: forwarding, ALU control decode, ALU, branch target and EX/MEM register.
module execute_stage
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic              stall,
  input  logic              flush,
  input  logic              RegWrite_EX,
  input  logic              Branch_EX,
  input  logic              Uncondbranch_EX,
  input  logic              MemRead_EX,
  input  logic              MemWrite_EX,
  input  logic              Mem2Reg_EX,
  input  logic              ALUSrc_EX,
  input  logic [1:0]        ALUOp_EX,
  input  logic [OPC_W-1:0]  Opcode_EX,
  input  logic [RD_W-1:0]   RD_EX,
  input  logic [DATA_W-1:0] PC_EX,
  input  logic [DATA_W-1:0] RegOutA_EX,
  input  logic [DATA_W-1:0] RegOutB_EX,
  input  logic [DATA_W-1:0] SignExt_EX,
  input  logic [1:0]        ForwardA,
  input  logic [1:0]        ForwardB,
  input  logic [DATA_W-1:0] FwdMEM_value,
  input  logic [DATA_W-1:0] FwdWB_value,
  output logic              RegWrite_MEM,
  output logic              Branch_MEM,
  output logic              Uncondbranch_MEM,
  output logic              MemRead_MEM,
  output logic              MemWrite_MEM,
  output logic              Mem2Reg_MEM,
  output logic              ALUzero_MEM,
  output logic [RD_W-1:0]   RD_MEM,
  output logic [DATA_W-1:0] RegOutB_MEM,
  output logic [DATA_W-1:0] ALUout_MEM,
  output logic [DATA_W-1:0] PCtarget_MEM
);

  function automatic alu_ctrl_e alu_decode(input logic [1:0] aluop,
                                           input logic [OPC_W-1:0] opcode);
    alu_ctrl_e c;
    c = ALU_ADD;
    if (aluop == ALUOP_PASSB) begin
      c = ALU_PASSB;
    end else if (aluop == ALUOP_RTYPE) begin
      case (opcode)
        OPC_SUB: c = ALU_SUB;
        OPC_AND: c = ALU_AND;
        OPC_ORR: c = ALU_ORR;
        default: c = ALU_ADD;
      endcase
    end
    return c;
  endfunction

  function automatic logic signed [DATA_W-1:0] fwd_sel(input logic [1:0] sel,
                                                       input logic [DATA_W-1:0] reg_v,
                                                       input logic [DATA_W-1:0] mem_v,
                                                       input logic [DATA_W-1:0] wb_v);
    logic signed [DATA_W-1:0] v;
    case (sel)
      FWD_MEM: v = $signed(mem_v);
      FWD_WB:  v = $signed(wb_v);
      default: v = $signed(reg_v);
    endcase
    return v;
  endfunction

  // ---- stage p0: operand select, ALU, branch target ----
  logic signed [DATA_W-1:0] opa_p0;
  logic signed [DATA_W-1:0] fwdb_p0;
  logic signed [DATA_W-1:0] opb_p0;
  logic signed [DATA_W-1:0] alu_res_p0;
  logic signed [DATA_W-1:0] target_p0;
  logic                     alu_zero_p0;
  alu_ctrl_e                alu_ctrl_p0;
  ex_mem_ctrl_t             ctrl_p0;

  assign opa_p0      = fwd_sel(ForwardA, RegOutA_EX, FwdMEM_value, FwdWB_value);
  assign fwdb_p0     = fwd_sel(ForwardB, RegOutB_EX, FwdMEM_value, FwdWB_value);
  assign opb_p0      = ALUSrc_EX ? $signed(SignExt_EX) : fwdb_p0;
  assign alu_ctrl_p0 = alu_decode(ALUOp_EX, Opcode_EX);
  assign target_p0   = $signed(PC_EX) + ($signed(SignExt_EX) <<< 2);

  alu #(.DATA_W(DATA_W)) u_alu (
    .a      (opa_p0),
    .b      (opb_p0),
    .ctrl   (alu_ctrl_p0),
    .result (alu_res_p0),
    .zero   (alu_zero_p0)
  );

  assign ctrl_p0 = '{reg_write:    RegWrite_EX,
                     branch:       Branch_EX,
                     uncondbranch: Uncondbranch_EX,
                     mem_read:     MemRead_EX,
                     mem_write:    MemWrite_EX,
                     mem2reg:      Mem2Reg_EX,
                     alu_zero:     alu_zero_p0};

  // ---- stage p1: EX/MEM register; flush squashes control but still loads data ----
  ex_mem_ctrl_t             ctrl_p1;
  logic [RD_W-1:0]          rd_p1;
  logic signed [DATA_W-1:0] storeb_p1;
  logic signed [DATA_W-1:0] alu_res_p1;
  logic signed [DATA_W-1:0] target_p1;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      ctrl_p1    <= '0;
      rd_p1      <= '0;
      storeb_p1  <= '0;
      alu_res_p1 <= '0;
      target_p1  <= '0;
    end else if (flush) begin
      ctrl_p1    <= '0;
      rd_p1      <= '0;
      storeb_p1  <= fwdb_p0;
      alu_res_p1 <= alu_res_p0;
      target_p1  <= target_p0;
    end else if (!stall) begin
      ctrl_p1    <= ctrl_p0;
      rd_p1      <= RD_EX;
      storeb_p1  <= fwdb_p0;
      alu_res_p1 <= alu_res_p0;
      target_p1  <= target_p0;
    end
  end

  assign RegWrite_MEM     = ctrl_p1.reg_write;
  assign Branch_MEM       = ctrl_p1.branch;
  assign Uncondbranch_MEM = ctrl_p1.uncondbranch;
  assign MemRead_MEM      = ctrl_p1.mem_read;
  assign MemWrite_MEM     = ctrl_p1.mem_write;
  assign Mem2Reg_MEM      = ctrl_p1.mem2reg;
  assign ALUzero_MEM      = ctrl_p1.alu_zero;
  assign RD_MEM           = rd_p1;
  assign RegOutB_MEM      = storeb_p1;
  assign ALUout_MEM       = alu_res_p1;
  assign PCtarget_MEM     = target_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        resetl = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        RegWrite_EX = 0, Branch_EX = 0, Uncondbranch_EX = 0, MemRead_EX = 0;
  logic        MemWrite_EX = 0, Mem2Reg_EX = 0, ALUSrc_EX = 0;
  logic [1:0]  ALUOp_EX = 0;
  logic [10:0] Opcode_EX = 0;
  logic [4:0]  RD_EX = 0;
  logic [63:0] PC_EX = 0, RegOutA_EX = 0, RegOutB_EX = 0, SignExt_EX = 0;
  logic [1:0]  ForwardA = 0, ForwardB = 0;
  logic [63:0] FwdMEM_value = 0, FwdWB_value = 0;

  logic        RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM;
  logic        MemWrite_MEM, Mem2Reg_MEM, ALUzero_MEM;
  logic [4:0]  RD_MEM;
  logic [63:0] RegOutB_MEM, ALUout_MEM, PCtarget_MEM;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected EX/MEM contents
  logic [6:0]  m_ctrl;  // {RegWrite,Branch,Uncond,MemRead,MemWrite,Mem2Reg,ALUzero}
  logic [4:0]  m_rd;
  logic [63:0] m_b, m_alu, m_pc;

  always #5 clk = ~clk;

  execute_stage #(.DATA_W(64), .RD_W(5)) dut (
    .clk(clk), .resetl(resetl), .stall(stall), .flush(flush),
    .RegWrite_EX(RegWrite_EX), .Branch_EX(Branch_EX), .Uncondbranch_EX(Uncondbranch_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .Mem2Reg_EX(Mem2Reg_EX),
    .ALUSrc_EX(ALUSrc_EX), .ALUOp_EX(ALUOp_EX), .Opcode_EX(Opcode_EX), .RD_EX(RD_EX),
    .PC_EX(PC_EX), .RegOutA_EX(RegOutA_EX), .RegOutB_EX(RegOutB_EX), .SignExt_EX(SignExt_EX),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .FwdMEM_value(FwdMEM_value), .FwdWB_value(FwdWB_value),
    .RegWrite_MEM(RegWrite_MEM), .Branch_MEM(Branch_MEM), .Uncondbranch_MEM(Uncondbranch_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .Mem2Reg_MEM(Mem2Reg_MEM),
    .ALUzero_MEM(ALUzero_MEM), .RD_MEM(RD_MEM), .RegOutB_MEM(RegOutB_MEM),
    .ALUout_MEM(ALUout_MEM), .PCtarget_MEM(PCtarget_MEM)
  );

  function automatic logic [63:0] pick(input logic [1:0] sel, input logic [63:0] r);
    if (sel == 2'b10) return FwdMEM_value;
    if (sel == 2'b01) return FwdWB_value;
    return r;
  endfunction

  // Plain-arithmetic view of what the instruction computes
  task automatic model_edge();
    logic [63:0] a, fb, b, res;
    a  = pick(ForwardA, RegOutA_EX);
    fb = pick(ForwardB, RegOutB_EX);
    b  = ALUSrc_EX ? SignExt_EX : fb;
    if (ALUOp_EX == 2'b01) res = b;
    else if (ALUOp_EX == 2'b10 && Opcode_EX == 11'b11001011000) res = a - b;
    else if (ALUOp_EX == 2'b10 && Opcode_EX == 11'b10001010000) res = a & b;
    else if (ALUOp_EX == 2'b10 && Opcode_EX == 11'b10101010000) res = a | b;
    else res = a + b;
    if (flush) begin
      m_ctrl = '0; m_rd = '0;
      m_b = fb; m_alu = res; m_pc = PC_EX + SignExt_EX * 64'd4;
    end else if (!stall) begin
      m_ctrl = {RegWrite_EX, Branch_EX, Uncondbranch_EX, MemRead_EX, MemWrite_EX,
                Mem2Reg_EX, (res == 64'd0)};
      m_rd = RD_EX; m_b = fb; m_alu = res; m_pc = PC_EX + SignExt_EX * 64'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetl) model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    {RegWrite_EX, Branch_EX, Uncondbranch_EX, MemRead_EX, MemWrite_EX, Mem2Reg_EX, ALUSrc_EX} = '0;
    ALUOp_EX = 0; Opcode_EX = 0; RD_EX = 0; PC_EX = 0; RegOutA_EX = 0; RegOutB_EX = 0;
    SignExt_EX = 0; ForwardA = 0; ForwardB = 0; FwdMEM_value = 0; FwdWB_value = 0;
    stall = 0; flush = 0;
  endtask

  task automatic test_reset();
    logic [6:0] c;
    m_ctrl = '0; m_rd = '0; m_b = '0; m_alu = '0; m_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    c = {RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM, ALUzero_MEM};
    checks++;
    if (c !== 7'd0 || RD_MEM !== 5'd0 || ALUout_MEM !== 64'd0 || PCtarget_MEM !== 64'd0 || RegOutB_MEM !== 64'd0) begin
      errors++; $display("FAIL reset_init: ctrl=%b rd=%0d alu=%h got nonzero, expected all 0", c, RD_MEM, ALUout_MEM);
    end
    // load nonzero state, then reset mid-cycle
    @(negedge clk); resetl = 1;
    RegWrite_EX = 1; MemRead_EX = 1; RD_EX = 5'd12; RegOutA_EX = 64'h33; RegOutB_EX = 64'h44;
    PC_EX = 64'h200; SignExt_EX = 64'h8;
    tick();
    checks++;
    if (RD_MEM !== 5'd12 || RegWrite_MEM !== 1'b1) begin
      errors++; $display("FAIL reset_preload: rd=%0d rw=%b expected rd=12 rw=1", RD_MEM, RegWrite_MEM);
    end
    #2 resetl = 0;
    #1;
    m_ctrl = '0; m_rd = '0; m_b = '0; m_alu = '0; m_pc = '0;
    c = {RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM, ALUzero_MEM};
    checks++;
    if (c !== 7'd0 || RD_MEM !== 5'd0 || ALUout_MEM !== 64'd0 || PCtarget_MEM !== 64'd0 || RegOutB_MEM !== 64'd0) begin
      errors++; $display("FAIL reset_async: ctrl=%b rd=%0d alu=%h pc=%h b=%h expected all 0",
                         c, RD_MEM, ALUout_MEM, PCtarget_MEM, RegOutB_MEM);
    end
    @(negedge clk); resetl = 1; clear_inputs(); RD_EX = 5'd5;
    tick();
    checks++;
    if (RD_MEM !== 5'd5) begin
      errors++; $display("FAIL reset_first_load: RD_MEM=%0d expected 5", RD_MEM);
    end
  endtask

  task automatic test_sub_zero();
    @(negedge clk); clear_inputs();
    ALUOp_EX = 2'b10; Opcode_EX = 11'b11001011000; RegOutA_EX = 64'd10; RegOutB_EX = 64'd10;
    RegWrite_EX = 1; RD_EX = 5'd3;
    tick();
    checks++;
    if (ALUout_MEM !== 64'd0 || ALUzero_MEM !== 1'b1) begin
      errors++; $display("FAIL sub_zero: alu=%h zero=%b expected 0/1", ALUout_MEM, ALUzero_MEM);
    end
    @(negedge clk); Opcode_EX = 11'b10101010000; RegOutA_EX = 64'hF0; RegOutB_EX = 64'h0F;
    tick();
    checks++;
    if (ALUout_MEM !== 64'hFF || ALUzero_MEM !== 1'b0) begin
      errors++; $display("FAIL orr: alu=%h zero=%b expected ff/0", ALUout_MEM, ALUzero_MEM);
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk); clear_inputs();
    ALUOp_EX = 2'b10; Opcode_EX = 11'b10001011000;
    ForwardA = 2'b10; FwdMEM_value = 64'h20; ForwardB = 2'b01; FwdWB_value = 64'h5;
    RegOutA_EX = 64'hDEAD; RegOutB_EX = 64'hBEEF;
    tick();
    checks++;
    if (ALUout_MEM !== 64'h25) begin
      errors++; $display("FAIL fwd_alu: ALUout_MEM=%h expected 25", ALUout_MEM);
    end
    checks++;
    if (RegOutB_MEM !== 64'h5) begin
      errors++; $display("FAIL fwd_store: RegOutB_MEM=%h expected 5", RegOutB_MEM);
    end
    @(negedge clk); ForwardA = 2'b11; RegOutA_EX = 64'd7; ALUOp_EX = 2'b00; ALUSrc_EX = 1; SignExt_EX = 64'd3;
    tick();
    checks++;
    if (ALUout_MEM !== 64'd10) begin
      errors++; $display("FAIL fwd_code11: ALUout_MEM=%h expected a", ALUout_MEM);
    end
  endtask

  task automatic test_branch();
    @(negedge clk); clear_inputs();
    PC_EX = 64'h100; SignExt_EX = 64'hFFFF_FFFF_FFFF_FFFC; Branch_EX = 1;
    ALUOp_EX = 2'b01; RegOutA_EX = 64'h77; RegOutB_EX = 64'd0;
    tick();
    checks++;
    if (PCtarget_MEM !== 64'hF0) begin
      errors++; $display("FAIL branch_target: PCtarget_MEM=%h expected f0", PCtarget_MEM);
    end
    checks++;
    if (ALUzero_MEM !== 1'b1 || Branch_MEM !== 1'b1) begin
      errors++; $display("FAIL cbz_zero: zero=%b branch=%b expected 1/1", ALUzero_MEM, Branch_MEM);
    end
  endtask

  task automatic test_flush_stall();
    @(negedge clk); clear_inputs();
    RD_EX = 5'd7; RegWrite_EX = 1; MemWrite_EX = 1; RegOutA_EX = 64'd100; RegOutB_EX = 64'd1;
    tick();
    checks++;
    if (RD_MEM !== 5'd7) begin
      errors++; $display("FAIL stall_pre: RD_MEM=%0d expected 7", RD_MEM);
    end
    @(negedge clk); stall = 1; RD_EX = 5'd9; RegOutA_EX = 64'd500;
    tick();
    checks++;
    if (RD_MEM !== 5'd7 || ALUout_MEM !== 64'd101 || RegWrite_MEM !== 1'b1) begin
      errors++; $display("FAIL stall_hold: rd=%0d alu=%0d rw=%b expected 7/101/1", RD_MEM, ALUout_MEM, RegWrite_MEM);
    end
    @(negedge clk); flush = 1;
    tick();
    checks++;
    if (RegWrite_MEM !== 1'b0 || MemWrite_MEM !== 1'b0 || RD_MEM !== 5'd0) begin
      errors++; $display("FAIL flush_over_stall: rw=%b mw=%b rd=%0d expected 0/0/0", RegWrite_MEM, MemWrite_MEM, RD_MEM);
    end
    checks++;
    if (ALUout_MEM !== 64'd501) begin
      errors++; $display("FAIL flush_data: ALUout_MEM=%0d expected 501", ALUout_MEM);
    end
  endtask

  task automatic test_wraparound();
    @(negedge clk); clear_inputs();
    ALUOp_EX = 2'b00; RegOutA_EX = 64'hFFFF_FFFF_FFFF_FFFF; ALUSrc_EX = 1; SignExt_EX = 64'd1;
    PC_EX = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    checks++;
    if (ALUout_MEM !== 64'd0 || ALUzero_MEM !== 1'b1) begin
      errors++; $display("FAIL wrap_add: alu=%h zero=%b expected 0/1", ALUout_MEM, ALUzero_MEM);
    end
    checks++;
    if (PCtarget_MEM !== 64'd0) begin
      errors++; $display("FAIL wrap_target: PCtarget_MEM=%h expected 0", PCtarget_MEM);
    end
  endtask

  task automatic test_random();
    logic [10:0] opcs [5];
    logic [6:0]  c;
    opcs[0] = 11'b10001011000; opcs[1] = 11'b11001011000; opcs[2] = 11'b10001010000;
    opcs[3] = 11'b10101010000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      opcs[4] = 11'($urandom);
      {RegWrite_EX, Branch_EX, Uncondbranch_EX, MemRead_EX, MemWrite_EX, Mem2Reg_EX, ALUSrc_EX} = 7'($urandom);
      ALUOp_EX = 2'($urandom); Opcode_EX = opcs[$urandom_range(0, 4)]; RD_EX = 5'($urandom);
      PC_EX = {$urandom, $urandom};
      RegOutA_EX = ($urandom_range(0, 3) == 0) ? RegOutB_EX : {$urandom, $urandom};
      RegOutB_EX = {$urandom, $urandom};
      SignExt_EX = ($urandom_range(0, 1) == 0) ? {{48{1'b1}}, 16'($urandom)} : 64'($urandom_range(0, 4096));
      ForwardA = 2'($urandom); ForwardB = 2'($urandom);
      FwdMEM_value = {$urandom, $urandom}; FwdWB_value = {$urandom, $urandom};
      stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 7) == 0);
      tick();
      c = {RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM, ALUzero_MEM};
      checks++;
      if (c !== m_ctrl || RD_MEM !== m_rd) begin
        errors++; $display("FAIL rand_ctrl[%0d]: ctrl=%b rd=%0d expected ctrl=%b rd=%0d", i, c, RD_MEM, m_ctrl, m_rd);
      end
      checks++;
      if (ALUout_MEM !== m_alu || RegOutB_MEM !== m_b || PCtarget_MEM !== m_pc) begin
        errors++; $display("FAIL rand_data[%0d]: alu=%h b=%h pc=%h expected alu=%h b=%h pc=%h",
                           i, ALUout_MEM, RegOutB_MEM, PCtarget_MEM, m_alu, m_b, m_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub_zero();
    test_forwarding();
    test_branch();
    test_flush_stall();
    test_wraparound();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
